vga_timing_core: RTL and testbench
==================================

Name: vga_timing_core

Overview:
- Pixel timing generator for the TinyVGA datapath. Produces hsync/vsync, display_on and the pixel coordinates consumed by the downstream pattern/colour stage.
- Also produces a free-running frame counter and line/frame strobes. The pattern stage's animation counter can then run in the main clock domain instead of being clocked from vsync.
- All outputs are registered and come from a single clock domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_POL, 0, sync polarity: 0 = active-low pulse, 1 = active-high pulse
- FCNT_W, 8, frame counter width

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset
- run  input  1  1 = timing advances; 0 = freeze all counters and outputs
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync
- display_on  output  1  high when (hpos,vpos) is in the visible area
- hpos  output  10  current pixel column, 0..H_TOTAL-1
- vpos  output  10  current line, 0..V_TOTAL-1
- line_start  output  1  one-cycle pulse when hpos becomes 0
- frame_start  output  1  one-cycle pulse when hpos and vpos both become 0
- frame_count  output  FCNT_W  frames started since reset, modulo 2^FCNT_W
- pix_stb  output  1  high on cycles where timing advanced

Reset: rst_n is a synchronous, active-low reset.

Behaviour:
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Internal counters h_cnt and v_cnt; all outputs are registered decodes of them.
- Latency: 1 cycle from counter to outputs. hpos/vpos are exactly h_cnt/v_cnt delayed one advance.
- Reset (rst_n = 0 at a clk edge), internal state: h_cnt = 0, v_cnt = 0.
- Reset, output values: hpos = 0, vpos = 0, display_on = 0, line_start = 0, frame_start = 0, frame_count = 0, pix_stb = 0, hsync = vsync = inactive level (!SYNC_POL).
- Advance: on each advancing cycle (run = 1 and pixel enable true), h_cnt increments.
- Horizontal wrap: at h_cnt = H_TOTAL-1, h_cnt goes to 0 and v_cnt increments.
- Vertical wrap: at v_cnt = V_TOTAL-1 with h_cnt wrapping, v_cnt goes to 0.
- Output decode, registered on each advancing cycle from the pre-increment counters:
  - display_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync is active when H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC
  - vsync is active when V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC
  - line_start = (h_cnt == 0)
  - frame_start = (h_cnt == 0 && v_cnt == 0)
- frame_count increments on the same edge that registers frame_start = 1 (except the first after reset; see below). It wraps from 2^FCNT_W-1 to 0 with no flag.
- First frame after reset: frame_start pulses with frame_count still 0. frame_count is first incremented at the second frame_start (value 1).
- run = 0:
  - counters and hpos/vpos/display_on/hsync/vsync/frame_count hold their values.
  - line_start, frame_start and pix_stb are forced to 0; strobes never repeat while frozen.
- Simultaneous run = 0 and reset: reset wins.
- Reset mid-line or mid-frame: outputs take reset values on that edge. The next advance starts at (0,0) with line_start = frame_start = 1.
- Widths: hpos and vpos are 10 bits; parameters must give H_TOTAL ≤ 1024 and V_TOTAL ≤ 1024 (elaboration-time check).

Optional Feature:
- Macro: VGA_TIMING_PIXDIV2_EN.
- Defined:
  - an internal toggle flop, reset to 0, divides clk by 2; the pixel enable is true only when the toggle is 1.
  - allows a 50 MHz clk to drive 25 MHz pixel timing.
  - pix_stb pulses every second cycle while run = 1.
  - outputs change only on enabled edges.
  - the toggle holds while run = 0.
- Undefined: the pixel enable is constantly 1, and pix_stb = run, registered with reset value 0.

Test Plan:
- Hold rst_n = 0 for 3 cycles, then release with run = 1 → during reset hsync = vsync = 1, display_on = 0, hpos = vpos = 0. First edge after release gives hpos = 0, vpos = 0, display_on = 1, line_start = frame_start = 1.
- Run one line → display_on falls at hpos = 640. hsync is low for exactly 96 cycles, hpos 656..751. At hpos 799 → 0, vpos increments to 1 and line_start pulses for 1 cycle.
- Run one full frame → vsync is low for vpos 490..491 (1600 cycles). frame_start repeats every 420000 cycles and frame_count goes 0 → 1 at the second frame_start.
- Drop run to 0 at hpos = 123 for 10 cycles → hpos stays 123 and pix_stb = 0. On resuming, hpos = 124 on the next edge.
- Assert rst_n = 0 at vpos = 300 → all outputs return to reset values on that edge. Frame timing restarts at (0,0) after release and frame_count = 0.
- With VGA_TIMING_PIXDIV2_EN defined → one line takes 1600 clk cycles, pix_stb alternates 0/1, and the hsync pulse lasts 192 cycles.

Source files
------------

// File: rtl/vga_timing_if.sv
// vga_timing_if: timing bus between vga_timing_core and the pattern/colour stage.
//   run         - consumer -> core, 1 = timing advances, 0 = freeze
//   hsync/vsync - sync pulses, polarity set by the core's SYNC_POL
//   display_on  - (hpos,vpos) lies in the visible area
//   hpos/vpos   - current pixel column / line
//   line_start  - one-cycle pulse when hpos becomes 0
//   frame_start - one-cycle pulse when hpos and vpos both become 0
//   frame_count - frames started since reset (first frame is frame 0)
//   pix_stb     - high on cycles where timing advanced
// master = timing core, slave = consumer.
interface vga_timing_if #(
  parameter int unsigned FCNT_W = 8
) ();
  logic              run;
  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic [9:0]        hpos;
  logic [9:0]        vpos;
  logic              line_start;
  logic              frame_start;
  logic [FCNT_W-1:0] frame_count;
  logic              pix_stb;

  modport master (
    input  run,
    output hsync, vsync, display_on, hpos, vpos,
    output line_start, frame_start, frame_count, pix_stb
  );

  modport slave (
    output run,
    input  hsync, vsync, display_on, hpos, vpos,
    input  line_start, frame_start, frame_count, pix_stb
  );
endinterface

// File: rtl/vga_timing_core.sv
// vga_timing_core: VGA pixel timing generator with frame counter and strobes.
// Ports:
//   clk   - system clock
//   rst_n - synchronous, active-low reset
//   bus   - vga_timing_if.master (run in; sync, position, strobes, frame count out)
// All outputs are registered decodes of the internal h/v counters, one advance late.
// Optional build macro VGA_TIMING_PIXDIV2_EN: pixel enable = clk/2 toggle, so a
// 50 MHz clk yields 25 MHz pixel timing. Undefined: timing advances every run cycle.
module vga_timing_core #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  vga_timing_if.master  bus
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END  = H_ACTIVE + H_FRONT + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END  = V_ACTIVE + V_FRONT + V_SYNC;
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Counters are 10 bits wide; reject totals that cannot be represented.
  if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_cfg
    $error("vga_timing_core: H_TOTAL and V_TOTAL must be in 1..1024");
  end

  logic [CNT_W-1:0]  r_h_cnt;
  logic [CNT_W-1:0]  r_v_cnt;
  logic              r_hsync;
  logic              r_vsync;
  logic              r_display_on;
  logic [CNT_W-1:0]  r_hpos;
  logic [CNT_W-1:0]  r_vpos;
  logic              r_line_start;
  logic              r_frame_start;
  logic [FCNT_W-1:0] r_frame_count;
  logic              r_pix_stb;
  logic              r_first_seen;

  logic w_pix_en;
  logic w_adv;
  logic w_h_last;
  logic w_v_last;
  logic w_disp;
  logic w_hs_act;
  logic w_vs_act;
  logic w_line_st;
  logic w_frame_st;

`ifdef VGA_TIMING_PIXDIV2_EN
  logic r_div;

  // clk/2 pixel enable; the toggle freezes with run so phase is kept across pauses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= 1'b0;
    end else if (bus.run) begin
      r_div <= ~r_div;
    end
  end

  assign w_pix_en = r_div;
`else
  assign w_pix_en = 1'b1;
`endif

  assign w_adv = bus.run & w_pix_en;

  // Decode of the current (pre-increment) counters.
  always_comb begin
    w_h_last   = (r_h_cnt == H_LAST);
    w_v_last   = (r_v_cnt == V_LAST);
    w_disp     = (32'(r_h_cnt) < H_ACTIVE) && (32'(r_v_cnt) < V_ACTIVE);
    w_hs_act   = (32'(r_h_cnt) >= HS_BEG) && (32'(r_h_cnt) < HS_END);
    w_vs_act   = (32'(r_v_cnt) >= VS_BEG) && (32'(r_v_cnt) < VS_END);
    w_line_st  = (r_h_cnt == '0);
    w_frame_st = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  // Raster position counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_adv) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  // Output registers; strobes are cleared on every non-advancing edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hsync       <= ~SYNC_POL;
      r_vsync       <= ~SYNC_POL;
      r_display_on  <= 1'b0;
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_count <= '0;
      r_pix_stb     <= 1'b0;
      r_first_seen  <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_pix_stb     <= w_adv;
      if (w_adv) begin
        r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
        r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
        r_display_on  <= w_disp;
        r_hpos        <= r_h_cnt;
        r_vpos        <= r_v_cnt;
        r_line_start  <= w_line_st;
        r_frame_start <= w_frame_st;
        // The first frame after reset is frame 0; count from the second one on.
        if (w_frame_st) begin
          r_first_seen <= 1'b1;
          if (r_first_seen) begin
            r_frame_count <= r_frame_count + FCNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.display_on  = r_display_on;
  assign bus.hpos        = r_hpos;
  assign bus.vpos        = r_vpos;
  assign bus.line_start  = r_line_start;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_count = r_frame_count;
  assign bus.pix_stb     = r_pix_stb;

endmodule

// File: tb/tb_vga_timing_core.sv
// tb_vga_timing_core: directed bench for vga_timing_core.
// Instance A uses the default 640x480 timing; instance B uses a tiny raster
// (16x12 total, active-high sync, 2-bit frame counter) so whole frames are short.
module tb_vga_timing_core;

  logic clk = 1'b0;
  logic rst_n_a;
  logic rst_n_b;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  vga_timing_if #(.FCNT_W(8)) bus_a ();
  vga_timing_if #(.FCNT_W(2)) bus_b ();

  vga_timing_core u_dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (bus_a.master)
  );

  vga_timing_core #(
    .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_ACTIVE (6), .V_FRONT (1), .V_SYNC (2), .V_BACK (3),
    .SYNC_POL (1'b1), .FCNT_W (2)
  ) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (bus_b.master)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n_a = 1'b0;
    bus_a.run = 1'b1;
    repeat (3) tick();
    n_checks++; if (bus_a.hsync !== 1'b1) $display("FAIL rst_hsync: got %b want 1", bus_a.hsync); else n_pass++;
    n_checks++; if (bus_a.vsync !== 1'b1) $display("FAIL rst_vsync: got %b want 1", bus_a.vsync); else n_pass++;
    n_checks++; if (bus_a.display_on !== 1'b0) $display("FAIL rst_display_on: got %b want 0", bus_a.display_on); else n_pass++;
    n_checks++; if (bus_a.hpos !== 10'd0 || bus_a.vpos !== 10'd0) $display("FAIL rst_pos: got %0d,%0d want 0,0", bus_a.hpos, bus_a.vpos); else n_pass++;
    n_checks++; if ({bus_a.line_start, bus_a.frame_start, bus_a.pix_stb} !== 3'b000) $display("FAIL rst_strobes: got %b want 000", {bus_a.line_start, bus_a.frame_start, bus_a.pix_stb}); else n_pass++;
    n_checks++; if (bus_a.frame_count !== 8'd0) $display("FAIL rst_fcnt: got %0d want 0", bus_a.frame_count); else n_pass++;
    rst_n_a = 1'b1;
`ifdef VGA_TIMING_PIXDIV2_EN
    tick();
    n_checks++; if ({bus_a.line_start, bus_a.pix_stb} !== 2'b00) $display("FAIL div_first_edge: got %b want 00", {bus_a.line_start, bus_a.pix_stb}); else n_pass++;
`endif
    tick();
    n_checks++; if (bus_a.hpos !== 10'd0 || bus_a.vpos !== 10'd0) $display("FAIL first_pos: got %0d,%0d want 0,0", bus_a.hpos, bus_a.vpos); else n_pass++;
    n_checks++; if (bus_a.display_on !== 1'b1) $display("FAIL first_display_on: got %b want 1", bus_a.display_on); else n_pass++;
    n_checks++; if ({bus_a.line_start, bus_a.frame_start, bus_a.pix_stb} !== 3'b111) $display("FAIL first_strobes: got %b want 111", {bus_a.line_start, bus_a.frame_start, bus_a.pix_stb}); else n_pass++;
    n_checks++; if (bus_a.frame_count !== 8'd0 || bus_a.hsync !== 1'b1) $display("FAIL first_fcnt_hsync: got %0d/%b want 0/1", bus_a.frame_count, bus_a.hsync); else n_pass++;
  endtask

`ifdef VGA_TIMING_PIXDIV2_EN
  // Each pixel takes two clocks; pix_stb alternates and the line is 1600 cycles.
  task automatic test_pixdiv();
    int err = 0, hs_low = 0, ls_cnt = 0;
    for (int k = 1; k <= 1600; k++) begin
      int eh;
      tick();
      eh = (k / 2) % 800;
      if (bus_a.pix_stb !== 1'((k % 2) == 0)) err++;
      if (bus_a.hpos !== 10'(eh) || bus_a.vpos !== 10'(k / 1600)) err++;
      if (bus_a.hsync === 1'b0) hs_low++;
      if (bus_a.line_start === 1'b1) ls_cnt++;
    end
    n_checks++; if (err != 0) $display("FAIL div_trace: got %0d errors want 0", err); else n_pass++;
    n_checks++; if (hs_low != 192) $display("FAIL div_hsync_width: got %0d want 192", hs_low); else n_pass++;
    n_checks++; if (ls_cnt != 1) $display("FAIL div_line_start: got %0d want 1", ls_cnt); else n_pass++;
    n_checks++; if (bus_a.hpos !== 10'd0 || bus_a.vpos !== 10'd1) $display("FAIL div_wrap: got %0d,%0d want 0,1", bus_a.hpos, bus_a.vpos); else n_pass++;
  endtask
`else
  // One full 800-pixel line starting from (0,0).
  task automatic test_line();
    int err = 0, hs_low = 0, hs_first = -1, de_fall = -1, ls_cnt = 0;
    for (int k = 1; k <= 800; k++) begin
      int eh, ev;
      tick();
      eh = k % 800;
      ev = k / 800;
      if (bus_a.hpos !== 10'(eh) || bus_a.vpos !== 10'(ev)) err++;
      if (bus_a.display_on !== 1'(eh < 640 && ev < 480)) err++;
      if (bus_a.hsync !== 1'(!(eh >= 656 && eh < 752))) err++;
      if (bus_a.line_start !== 1'(eh == 0) || bus_a.frame_start !== 1'b0 || bus_a.pix_stb !== 1'b1) err++;
      if (bus_a.hsync === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(bus_a.hpos);
      end
      if (bus_a.display_on === 1'b0 && de_fall < 0) de_fall = int'(bus_a.hpos);
      if (bus_a.line_start === 1'b1) ls_cnt++;
    end
    n_checks++; if (err != 0) $display("FAIL line_trace: got %0d errors want 0", err); else n_pass++;
    n_checks++; if (hs_low != 96) $display("FAIL hsync_width: got %0d want 96", hs_low); else n_pass++;
    n_checks++; if (hs_first != 656) $display("FAIL hsync_start: got %0d want 656", hs_first); else n_pass++;
    n_checks++; if (de_fall != 640) $display("FAIL display_fall: got %0d want 640", de_fall); else n_pass++;
    n_checks++; if (ls_cnt != 1) $display("FAIL line_start_count: got %0d want 1", ls_cnt); else n_pass++;
    n_checks++; if (bus_a.hpos !== 10'd0 || bus_a.vpos !== 10'd1) $display("FAIL line_wrap: got %0d,%0d want 0,1", bus_a.hpos, bus_a.vpos); else n_pass++;
    tick();
    n_checks++; if (bus_a.line_start !== 1'b0 || bus_a.hpos !== 10'd1) $display("FAIL line_start_pulse: got %b@%0d want 0@1", bus_a.line_start, bus_a.hpos); else n_pass++;
  endtask

  // Freeze at hpos 123 for 10 cycles, then resume.
  task automatic test_freeze();
    int budget = 0, err = 0;
    while (bus_a.hpos !== 10'd123 && budget < 200) begin
      tick();
      budget++;
    end
    n_checks++; if (bus_a.hpos !== 10'd123) $display("FAIL freeze_reach: got %0d want 123", bus_a.hpos); else n_pass++;
    bus_a.run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus_a.hpos !== 10'd123 || bus_a.pix_stb !== 1'b0 || bus_a.line_start !== 1'b0) err++;
    end
    n_checks++; if (err != 0) $display("FAIL freeze_hold: got %0d errors want 0", err); else n_pass++;
    n_checks++; if (bus_a.vpos !== 10'd1 || bus_a.display_on !== 1'b1) $display("FAIL freeze_state: got %0d/%b want 1/1", bus_a.vpos, bus_a.display_on); else n_pass++;
    bus_a.run = 1'b1;
    tick();
    n_checks++; if (bus_a.hpos !== 10'd124 || bus_a.pix_stb !== 1'b1) $display("FAIL freeze_resume: got %0d/%b want 124/1", bus_a.hpos, bus_a.pix_stb); else n_pass++;
  endtask

  // Five small frames: 16x12 raster = 192 cycles per frame, 2-bit frame counter.
  task automatic test_frame();
    int err = 0, vs_cnt = 0, vs_first = -1, fs_cnt = 0;
    rst_n_b = 1'b0;
    bus_b.run = 1'b1;
    repeat (3) tick();
    n_checks++; if ({bus_b.hsync, bus_b.vsync} !== 2'b00) $display("FAIL b_rst_sync: got %b want 00", {bus_b.hsync, bus_b.vsync}); else n_pass++;
    rst_n_b = 1'b1;
    for (int n = 0; n <= 960; n++) begin
      int eh, ev;
      tick();
      eh = n % 16;
      ev = (n / 16) % 12;
      if (bus_b.hpos !== 10'(eh) || bus_b.vpos !== 10'(ev)) err++;
      if (bus_b.display_on !== 1'(eh < 8 && ev < 6)) err++;
      if (bus_b.hsync !== 1'(eh >= 10 && eh < 13) || bus_b.vsync !== 1'(ev >= 7 && ev < 9)) err++;
      if (bus_b.line_start !== 1'(eh == 0) || bus_b.frame_start !== 1'((n % 192) == 0)) err++;
      if (bus_b.frame_count !== 2'((n / 192) % 4)) err++;
      if (n < 192 && bus_b.vsync === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = int'(bus_b.vpos);
      end
      if (bus_b.frame_start === 1'b1) fs_cnt++;
      if (n == 192) begin
        n_checks++; if (bus_b.frame_count !== 2'd1 || bus_b.frame_start !== 1'b1) $display("FAIL second_frame: got %0d/%b want 1/1", bus_b.frame_count, bus_b.frame_start); else n_pass++;
      end
      if (n == 768) begin
        n_checks++; if (bus_b.frame_count !== 2'd0) $display("FAIL fcnt_wrap: got %0d want 0", bus_b.frame_count); else n_pass++;
      end
    end
    n_checks++; if (err != 0) $display("FAIL frame_trace: got %0d errors want 0", err); else n_pass++;
    n_checks++; if (vs_cnt != 32) $display("FAIL vsync_width: got %0d want 32", vs_cnt); else n_pass++;
    n_checks++; if (vs_first != 7) $display("FAIL vsync_start: got %0d want 7", vs_first); else n_pass++;
    n_checks++; if (fs_cnt != 6) $display("FAIL frame_start_count: got %0d want 6", fs_cnt); else n_pass++;
  endtask

  // Reset (together with run=0) in the middle of a frame, then restart.
  task automatic test_midframe_reset();
    int budget = 0;
    while (bus_b.vpos !== 10'd4 && budget < 200) begin
      tick();
      budget++;
    end
    n_checks++; if (bus_b.vpos !== 10'd4 || bus_b.frame_count !== 2'd1) $display("FAIL mid_reach: got %0d/%0d want 4/1", bus_b.vpos, bus_b.frame_count); else n_pass++;
    rst_n_b = 1'b0;
    bus_b.run = 1'b0;
    tick();
    n_checks++; if (bus_b.hpos !== 10'd0 || bus_b.vpos !== 10'd0 || bus_b.frame_count !== 2'd0) $display("FAIL mid_rst_pos: got %0d,%0d,%0d want 0,0,0", bus_b.hpos, bus_b.vpos, bus_b.frame_count); else n_pass++;
    n_checks++; if ({bus_b.display_on, bus_b.line_start, bus_b.frame_start, bus_b.pix_stb, bus_b.hsync, bus_b.vsync} !== 6'b0) $display("FAIL mid_rst_flags: got %b want 000000", {bus_b.display_on, bus_b.line_start, bus_b.frame_start, bus_b.pix_stb, bus_b.hsync, bus_b.vsync}); else n_pass++;
    rst_n_b = 1'b1;
    bus_b.run = 1'b1;
    tick();
    n_checks++; if (bus_b.hpos !== 10'd0 || bus_b.vpos !== 10'd0 || {bus_b.line_start, bus_b.frame_start} !== 2'b11 || bus_b.frame_count !== 2'd0) $display("FAIL restart: got %0d,%0d ls/fs %b fc %0d want 0,0 11 0", bus_b.hpos, bus_b.vpos, {bus_b.line_start, bus_b.frame_start}, bus_b.frame_count); else n_pass++;
    repeat (192) tick();
    n_checks++; if (bus_b.frame_start !== 1'b1 || bus_b.frame_count !== 2'd1) $display("FAIL restart_second_frame: got %b/%0d want 1/1", bus_b.frame_start, bus_b.frame_count); else n_pass++;
  endtask
`endif

  initial begin
    rst_n_a   = 1'b0;
    rst_n_b   = 1'b0;
    bus_a.run = 1'b0;
    bus_b.run = 1'b0;
    test_reset();
`ifdef VGA_TIMING_PIXDIV2_EN
    test_pixdiv();
`else
    test_line();
    test_freeze();
    test_frame();
    test_midframe_reset();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
